// File: rtl/aemb2_dwbif.sv
// AEMB2 data-side Wishbone bus interface.
// Turns execute-stage load/store requests into single Wishbone cycles with
// big-endian byte lanes and returns right-justified, zero-extended load data.
module aemb2_dwbif #(
  parameter int AEMB_DWB = 32
) (
  input  logic                gclk,
  input  logic                grst,
  input  logic                dena,
  input  logic                ex_ld,
  input  logic                ex_st,
  input  logic [1:0]          ex_siz,
  input  logic [AEMB_DWB-1:0] ex_adr,
  input  logic [31:0]         ex_dat,
  input  logic                dwb_ack_i,
  input  logic [31:0]         dwb_dat_i,
  output logic [AEMB_DWB-3:0] dwb_adr_o,
  output logic [31:0]         dwb_dat_o,
  output logic [3:0]          dwb_sel_o,
  output logic                dwb_stb_o,
  output logic                dwb_cyc_o,
  output logic                dwb_we_o,
  output logic                dwb_fb,
  output logic [31:0]         mem_dat
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t              state_q;
  logic [AEMB_DWB-3:0] adr_q;
  logic [31:0]         dat_q;
  logic [3:0]          sel_q;
  logic                stb_q;
  logic                we_q;
  logic [31:0]         mem_q;

  logic                req_s;
  logic [3:0]          sel_d;
  logic [31:0]         dat_d;
  logic [31:0]         load_s;

  // A new request is only accepted when the pipe advances.
  assign req_s = dena & (ex_ld | ex_st);

  // Byte-lane select and replicated store data for the incoming request.
  always_comb begin
    sel_d = 4'b0000;
    dat_d = 32'h0000_0000;
    case (ex_siz)
      2'b00: begin
        dat_d = {4{ex_dat[7:0]}};
        case (ex_adr[1:0])
          2'b00:   sel_d = 4'b1000;
          2'b01:   sel_d = 4'b0100;
          2'b10:   sel_d = 4'b0010;
          2'b11:   sel_d = 4'b0001;
          default: sel_d = 4'b0000;
        endcase
      end
      2'b01: begin
        dat_d = {2{ex_dat[15:0]}};
        if (ex_adr[1]) begin
          sel_d = 4'b0011;
        end else begin
          sel_d = 4'b1100;
        end
      end
      default: begin
        // Word and the reserved size code both move all four lanes.
        dat_d = ex_dat;
        sel_d = 4'b1111;
      end
    endcase
  end

  // Right-justify the lane(s) addressed by the outstanding load.
  always_comb begin
    load_s = dwb_dat_i;
    case (sel_q)
      4'b1000: load_s = {24'h00_0000, dwb_dat_i[31:24]};
      4'b0100: load_s = {24'h00_0000, dwb_dat_i[23:16]};
      4'b0010: load_s = {24'h00_0000, dwb_dat_i[15:8]};
      4'b0001: load_s = {24'h00_0000, dwb_dat_i[7:0]};
      4'b1100: load_s = {16'h0000, dwb_dat_i[31:16]};
      4'b0011: load_s = {16'h0000, dwb_dat_i[15:0]};
      default: load_s = dwb_dat_i;
    endcase
  end

  // Bus cycle state machine; an ack can retire one access and start the next on the same edge.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q <= ST_IDLE;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      adr_q   <= '0;
      dat_q   <= 32'h0000_0000;
      mem_q   <= 32'h0000_0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_s) begin
            state_q <= ST_WAIT;
            stb_q   <= 1'b1;
            we_q    <= ex_st;
            sel_q   <= sel_d;
            adr_q   <= ex_adr[AEMB_DWB-1:2];
            dat_q   <= dat_d;
          end
        end
        ST_WAIT: begin
          if (dwb_ack_i) begin
            if (!we_q) begin
              mem_q <= load_s;
            end
            if (req_s) begin
              state_q <= ST_WAIT;
              stb_q   <= 1'b1;
              we_q    <= ex_st;
              sel_q   <= sel_d;
              adr_q   <= ex_adr[AEMB_DWB-1:2];
              dat_q   <= dat_d;
            end else begin
              state_q <= ST_IDLE;
              stb_q   <= 1'b0;
              we_q    <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          stb_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign dwb_adr_o = adr_q;
  assign dwb_dat_o = dat_q;
  assign dwb_sel_o = sel_q;
  assign dwb_stb_o = stb_q;
  assign dwb_cyc_o = stb_q;
  assign dwb_we_o  = we_q;
  assign mem_dat   = mem_q;
  assign dwb_fb    = ~stb_q | dwb_ack_i;

endmodule

// File: tb/tb_aemb2_dwbif.sv
// Self-checking bench for aemb2_dwbif: directed scenarios with literal
// expectations plus a randomized run against a transaction-level model.
module tb_aemb2_dwbif;

  logic        gclk;
  logic        grst;
  logic        dena;
  logic        ex_ld;
  logic        ex_st;
  logic [1:0]  ex_siz;
  logic [31:0] ex_adr;
  logic [31:0] ex_dat;
  logic        dwb_ack_i;
  logic [31:0] dwb_dat_i;
  logic [29:0] dwb_adr_o;
  logic [31:0] dwb_dat_o;
  logic [3:0]  dwb_sel_o;
  logic        dwb_stb_o;
  logic        dwb_cyc_o;
  logic        dwb_we_o;
  logic        dwb_fb;
  logic [31:0] mem_dat;

  int n_chk;
  int n_pass;

  // Model: one outstanding transaction described by its request fields.
  logic        m_busy;
  logic        m_we;
  logic [1:0]  m_siz;
  logic [31:0] m_badr;
  logic [31:0] m_wdat;
  logic [31:0] m_mem;
  logic        m_rst;

  aemb2_dwbif #(.AEMB_DWB(32)) dut (
    .gclk(gclk), .grst(grst), .dena(dena), .ex_ld(ex_ld), .ex_st(ex_st),
    .ex_siz(ex_siz), .ex_adr(ex_adr), .ex_dat(ex_dat),
    .dwb_ack_i(dwb_ack_i), .dwb_dat_i(dwb_dat_i),
    .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_sel_o(dwb_sel_o),
    .dwb_stb_o(dwb_stb_o), .dwb_cyc_o(dwb_cyc_o), .dwb_we_o(dwb_we_o),
    .dwb_fb(dwb_fb), .mem_dat(mem_dat)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_sel(input logic [1:0] siz, input logic [31:0] a);
    logic [3:0] one_byte;
    one_byte = 4'b1000;
    if (siz == 2'b00) return one_byte >> a[1:0];
    if (siz == 2'b01) return a[1] ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdat(input logic [1:0] siz, input logic [31:0] d);
    if (siz == 2'b00) return (d & 32'h0000_00FF) * 32'h0101_0101;
    if (siz == 2'b01) return (d & 32'h0000_FFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] siz, input logic [31:0] a, input logic [31:0] d);
    int sh;
    if (siz == 2'b00) begin
      sh = 8 * (3 - int'(a[1:0]));
      return (d >> sh) & 32'h0000_00FF;
    end
    if (siz == 2'b01) begin
      sh = a[1] ? 0 : 16;
      return (d >> sh) & 32'h0000_FFFF;
    end
    return d;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic done;
    if (grst) begin
      m_busy = 1'b0; m_we = 1'b0; m_mem = 32'h0; m_rst = 1'b1;
    end else begin
      done = m_busy && dwb_ack_i;
      if (done && !m_we) m_mem = exp_load(m_siz, m_badr, dwb_dat_i);
      if ((!m_busy || done) && dena && (ex_ld || ex_st)) begin
        m_busy = 1'b1;
        m_we   = ex_st;
        m_siz  = ex_siz;
        m_badr = ex_adr;
        m_wdat = exp_wdat(ex_siz, ex_dat);
        m_rst  = 1'b0;
      end else if (done) begin
        m_busy = 1'b0;
        m_we   = 1'b0;
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    chk("stb", 32'(dwb_stb_o), 32'(m_busy));
    chk("cyc", 32'(dwb_cyc_o), 32'(m_busy));
    chk("we", 32'(dwb_we_o), 32'(m_we));
    chk("mem_dat", mem_dat, m_mem);
    chk("fb", 32'(dwb_fb), 32'(!m_busy || dwb_ack_i));
    if (m_busy) begin
      chk("adr", 32'(dwb_adr_o), m_badr >> 2);
      chk("sel", 32'(dwb_sel_o), 32'(exp_sel(m_siz, m_badr)));
      chk("dat_o", dwb_dat_o, m_wdat);
    end else if (m_rst) begin
      chk("adr_rst", 32'(dwb_adr_o), 32'h0);
      chk("sel_rst", 32'(dwb_sel_o), 32'h0);
      chk("dat_rst", dwb_dat_o, 32'h0);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    grst = 1'b0; dena = 1'b1; ex_ld = 1'b0; ex_st = 1'b0; ex_siz = 2'b10;
    ex_adr = 32'h0; ex_dat = 32'h0; dwb_ack_i = 1'b0; dwb_dat_i = 32'h0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    m_busy = 1'b0; m_we = 1'b0; m_siz = 2'b10; m_badr = 32'h0;
    m_wdat = 32'h0; m_mem = 32'h0; m_rst = 1'b1;
    idle_inputs();
    grst = 1'b1;
    #1;
    step(); step();
    chk("rst_fb", 32'(dwb_fb), 32'd1);
    chk("rst_stb", 32'(dwb_stb_o), 32'd0);
    grst = 1'b0;

    // Byte load, two wait states.
    ex_ld = 1'b1; ex_siz = 2'b00; ex_adr = 32'h0000_0102;
    step();
    ex_ld = 1'b0;
    chk("bl_sel", 32'(dwb_sel_o), 32'h2);
    chk("bl_we", 32'(dwb_we_o), 32'd0);
    #1 chk("bl_fb1", 32'(dwb_fb), 32'd0);
    step();
    #1 chk("bl_fb2", 32'(dwb_fb), 32'd0);
    dwb_ack_i = 1'b1; dwb_dat_i = 32'hAABB_CCDD;
    step();
    dwb_ack_i = 1'b0;
    chk("bl_mem", mem_dat, 32'h0000_00CC);
    chk("bl_stb", 32'(dwb_stb_o), 32'd0);

    // Half store.
    ex_st = 1'b1; ex_siz = 2'b01; ex_adr = 32'h0000_0006; ex_dat = 32'h1234_5678;
    step();
    ex_st = 1'b0;
    chk("hs_sel", 32'(dwb_sel_o), 32'h3);
    chk("hs_dat", dwb_dat_o, 32'h5678_5678);
    chk("hs_adr", 32'(dwb_adr_o), 32'h1);
    chk("hs_we", 32'(dwb_we_o), 32'd1);
    dwb_ack_i = 1'b1; dwb_dat_i = 32'hDEAD_BEEF;
    step();
    dwb_ack_i = 1'b0;
    chk("hs_stb", 32'(dwb_stb_o), 32'd0);
    chk("hs_mem", mem_dat, 32'h0000_00CC);

    // Back-to-back word loads with a zero-wait slave.
    ex_ld = 1'b1; ex_siz = 2'b10; ex_adr = 32'h0000_0010;
    dwb_ack_i = 1'b1; dwb_dat_i = 32'h1111_1111;
    #1 chk("bb_fb0", 32'(dwb_fb), 32'd1);
    step();
    chk("bb_stb1", 32'(dwb_stb_o), 32'd1);
    ex_adr = 32'h0000_0014;
    #1 chk("bb_fb1", 32'(dwb_fb), 32'd1);
    step();
    chk("bb_stb2", 32'(dwb_stb_o), 32'd1);
    chk("bb_mem1", mem_dat, 32'h1111_1111);
    ex_ld = 1'b0; dwb_dat_i = 32'h2222_2222;
    #1 chk("bb_fb2", 32'(dwb_fb), 32'd1);
    step();
    chk("bb_mem2", mem_dat, 32'h2222_2222);
    chk("bb_stb3", 32'(dwb_stb_o), 32'd0);
    dwb_ack_i = 1'b0;

    // Ack with dena low completes without a new request.
    ex_ld = 1'b1; ex_adr = 32'h0000_0020;
    step();
    dena = 1'b0; dwb_ack_i = 1'b1; dwb_dat_i = 32'h3333_4444;
    step();
    chk("nd_stb", 32'(dwb_stb_o), 32'd0);
    chk("nd_mem", mem_dat, 32'h3333_4444);
    dwb_ack_i = 1'b0;
    step();
    chk("nd_idle", 32'(dwb_stb_o), 32'd0);
    dena = 1'b1; ex_ld = 1'b0;

    // Reset during WAIT discards a simultaneous ack.
    ex_ld = 1'b1; ex_siz = 2'b00; ex_adr = 32'h0000_0001;
    step();
    ex_ld = 1'b0; grst = 1'b1; dwb_ack_i = 1'b1; dwb_dat_i = 32'h5555_6666;
    step();
    chk("rm_stb", 32'(dwb_stb_o), 32'd0);
    chk("rm_sel", 32'(dwb_sel_o), 32'd0);
    chk("rm_mem", mem_dat, 32'd0);
    chk("rm_fb", 32'(dwb_fb), 32'd1);
    grst = 1'b0; dwb_ack_i = 1'b0;

    // Load and store together behave as a store.
    ex_ld = 1'b1; ex_st = 1'b1; ex_siz = 2'b10; ex_dat = 32'hCAFE_F00D;
    step();
    ex_ld = 1'b0; ex_st = 1'b0;
    chk("cf_we", 32'(dwb_we_o), 32'd1);
    chk("cf_sel", 32'(dwb_sel_o), 32'hF);
    chk("cf_dat", dwb_dat_o, 32'hCAFE_F00D);
    dwb_ack_i = 1'b1;
    step();
    dwb_ack_i = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      grst      = ($urandom_range(0, 99) == 0);
      dena      = ($urandom_range(0, 3) != 0);
      ex_ld     = $urandom_range(0, 1) == 1;
      ex_st     = $urandom_range(0, 2) == 0;
      ex_siz    = 2'($urandom_range(0, 3));
      ex_adr    = $urandom;
      ex_dat    = $urandom;
      dwb_ack_i = $urandom_range(0, 1) == 1;
      dwb_dat_i = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
